// File: rtl/cic_comp_fir_pkg.sv
// Shared types and constants for the CIC droop-compensation FIR.
// Default taps are Q1.15 with a DC gain of 1.125.
package cic_comp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    ROUND = 2'd2
  } state_e;

  localparam int COMP_NUM_TAPS    = 7;
  localparam int COMP_COEFF_WIDTH = 16;

  localparam logic signed [COMP_COEFF_WIDTH-1:0] COMP_COEFFS [COMP_NUM_TAPS] = '{
    -16'sh0800, 16'sh0000, 16'sh2000, 16'sh6000, 16'sh2000, 16'sh0000, -16'sh0800
  };

  // Largest and smallest two's-complement values representable in w bits.
  function automatic longint sat_max(input int w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/cic_comp_fir_if.sv
// Sample/strobe bundle between the CIC decimator, this filter and the next stage.
interface cic_comp_fir_if #(
  parameter int DATA_WIDTH = 16
);
  logic                         valid_in;
  logic                         bypass;
  logic signed [DATA_WIDTH-1:0] comp_in;
  logic signed [DATA_WIDTH-1:0] comp_out;
  logic                         valid_out;
  logic                         overflow;
  logic                         underflow;
  logic                         busy;
  logic                         drop;

  modport master (
    output valid_in, bypass, comp_in,
    input  comp_out, valid_out, overflow, underflow, busy, drop
  );

  modport slave (
    input  valid_in, bypass, comp_in,
    output comp_out, valid_out, overflow, underflow, busy, drop
  );
endinterface

// File: rtl/cic_comp_fir_round_sat.sv
// Round-half-up, rescale and saturate the MAC accumulator back to sample width.
module comp_round_sat
  import cic_comp_pkg::*;
#(
  parameter int ACC_WIDTH  = 35,
  parameter int DATA_WIDTH = 16,
  parameter int ACC_FRAC   = 30,
  parameter int OUT_FRAC   = 15
) (
  input  logic signed [ACC_WIDTH-1:0]  acc_i,
  output logic signed [DATA_WIDTH-1:0] data_o,
  output logic                         overflow_o,
  output logic                         underflow_o
);
  localparam int SHIFT = ACC_FRAC - OUT_FRAC;
  localparam logic signed [ACC_WIDTH-1:0] HALF  = ACC_WIDTH'(longint'(1) <<< (SHIFT - 1));
  localparam logic signed [ACC_WIDTH-1:0] MAX_V = ACC_WIDTH'(sat_max(DATA_WIDTH));
  localparam logic signed [ACC_WIDTH-1:0] MIN_V = ACC_WIDTH'(sat_min(DATA_WIDTH));

  logic signed [ACC_WIDTH-1:0] rounded;
  logic signed [ACC_WIDTH-1:0] shifted;

  always_comb begin
    rounded     = acc_i + HALF;
    shifted     = rounded >>> SHIFT;
    overflow_o  = 1'b0;
    underflow_o = 1'b0;
    data_o      = shifted[DATA_WIDTH-1:0];
    if (shifted > MAX_V) begin
      data_o     = MAX_V[DATA_WIDTH-1:0];
      overflow_o = 1'b1;
    end else if (shifted < MIN_V) begin
      data_o      = MIN_V[DATA_WIDTH-1:0];
      underflow_o = 1'b1;
    end
  end
endmodule

// File: rtl/cic_comp_fir.sv
// Serial-MAC compensation FIR behind the CIC decimator: one multiplier,
// NUM_TAPS MAC cycles per input sample, then a single round/saturate cycle.
module cic_comp_fir
  import cic_comp_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int DATA_FRAC   = 15,
  parameter int COEFF_WIDTH = 16,
  parameter int COEFF_FRAC  = 15,
  parameter int NUM_TAPS    = 7,
  parameter logic signed [COEFF_WIDTH-1:0] COEFFS [NUM_TAPS] = COMP_COEFFS
) (
  input  logic           clk,
  input  logic           rst_n,
  cic_comp_fir_if.slave  bus
);
  localparam int ACC_WIDTH  = DATA_WIDTH + COEFF_WIDTH + $clog2(NUM_TAPS);
  localparam int PROD_WIDTH = DATA_WIDTH + COEFF_WIDTH;
  localparam int PTR_W      = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(NUM_TAPS - 1);

  state_e                        state_q;
  logic signed [DATA_WIDTH-1:0]  dline_q [NUM_TAPS];
  logic [PTR_W-1:0]              wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]              newest_q;
  logic [PTR_W-1:0]              k_q;
  logic [PTR_W-1:0]              rd_idx;
  logic signed [ACC_WIDTH-1:0]   acc_q;
  logic signed [PROD_WIDTH-1:0]  prod;
  logic signed [ACC_WIDTH-1:0]   prod_ext;
  logic signed [DATA_WIDTH-1:0]  comp_out_q;
  logic                          valid_out_q, overflow_q, underflow_q, drop_q;
  logic signed [DATA_WIDTH-1:0]  rs_data;
  logic                          rs_ovf, rs_udf;

  // Tap k pairs with the sample k steps older than the newest; modular
  // subtraction in PTR_W bits folds the wrap back into 0..NUM_TAPS-1.
  always_comb begin
    wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
    if (newest_q >= k_q) rd_idx = newest_q - k_q;
    else                 rd_idx = PTR_W'(NUM_TAPS) + newest_q - k_q;
    prod     = COEFFS[k_q] * dline_q[rd_idx];
    prod_ext = ACC_WIDTH'(prod);
  end

  comp_round_sat #(
    .ACC_WIDTH  (ACC_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_FRAC   (DATA_FRAC + COEFF_FRAC),
    .OUT_FRAC   (DATA_FRAC)
  ) u_round_sat (
    .acc_i       (acc_q),
    .data_o      (rs_data),
    .overflow_o  (rs_ovf),
    .underflow_o (rs_udf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      newest_q    <= '0;
      k_q         <= '0;
      acc_q       <= '0;
      comp_out_q  <= '0;
      valid_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      drop_q      <= 1'b0;
      for (int i = 0; i < NUM_TAPS; i++) dline_q[i] <= '0;
    end else begin
      valid_out_q <= 1'b0;
      drop_q      <= 1'b0;
      if (bus.bypass) begin
        // History keeps tracking the input so filtering resumes cleanly.
        state_q     <= IDLE;
        valid_out_q <= bus.valid_in;
        comp_out_q  <= bus.comp_in;
        overflow_q  <= 1'b0;
        underflow_q <= 1'b0;
        if (bus.valid_in) begin
          dline_q[wr_ptr_q] <= bus.comp_in;
          wr_ptr_q          <= wr_ptr_d;
        end
      end else begin
        case (state_q)
          IDLE: begin
            if (bus.valid_in) begin
              dline_q[wr_ptr_q] <= bus.comp_in;
              newest_q          <= wr_ptr_q;
              wr_ptr_q          <= wr_ptr_d;
              acc_q             <= '0;
              k_q               <= '0;
              state_q           <= MAC;
            end
          end
          MAC: begin
            acc_q  <= acc_q + prod_ext;
            drop_q <= bus.valid_in;
            if (k_q == LAST) state_q <= ROUND;
            else             k_q     <= k_q + 1'b1;
          end
          ROUND: begin
            comp_out_q  <= rs_data;
            overflow_q  <= rs_ovf;
            underflow_q <= rs_udf;
            valid_out_q <= 1'b1;
            drop_q      <= bus.valid_in;
            state_q     <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.comp_out  = comp_out_q;
  assign bus.valid_out = valid_out_q;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
  assign bus.drop      = drop_q;
  assign bus.busy      = (state_q != IDLE);
endmodule
